// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Holds the word-addressed PC, issues one read at a time to a fixed-latency
// instruction memory, presents the returned word to the decode/branch stage
// and latches the branch stage's next PC when that instruction retires.
// A fetched word whose opcode equals HALT_OPCODE parks the unit until reset.
module instr_fetch_unit #(
    parameter int unsigned MEM_LAT     = 1,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    output logic [31:0] pc_out,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    // Latency fits in three bits because the memory latency is at most 7.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t     state;
    state_t     state_next;
    logic [2:0] lat_cnt;
    logic       load_cnt;
    logic       capture;
    logic       retire;
    logic       is_halt_word;

    assign is_halt_word = (imem_rdata[31:26] == HALT_OPCODE);

    // State register; reset abandons whatever fetch was in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_next = state;
        imem_rd_en = 1'b0;
        load_cnt   = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                imem_rd_en = 1'b1;
                load_cnt   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = is_halt_word ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    retire     = 1'b1;
                    state_next = ISSUE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts the cycles until the outstanding read data is due on imem_rdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cnt <= 3'd0;
        end else if (load_cnt) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == WAIT && lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // PC, captured instruction, valid flag and retire counter; a halt word is
    // still loaded into instr but never marked valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_out       <= 32'd0;
            instr        <= 32'd0;
            instr_valid  <= 1'b0;
            retire_count <= 32'd0;
        end else begin
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= !is_halt_word;
            end
            if (retire) begin
                pc_out       <= pc_next;
                retire_count <= retire_count + 32'd1;
                instr_valid  <= 1'b0;
            end
        end
    end

    assign imem_addr = pc_out;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Drives two fetch units (memory latency 1 and 3) with randomized stall,
// pc_next and reset, each fed by its own latency-accurate instruction ROM,
// and compares every output every cycle against a cycle-count reference.
module tb_instr_fetch_unit;

    localparam int NI = 2;

    logic        clock = 1'b0;
    logic        reset      [NI];
    logic        stall      [NI];
    logic [31:0] pcNext     [NI];
    logic [31:0] imemRdata  [NI];
    logic [31:0] imemAddr   [NI];
    logic        imemRdEn   [NI];
    logic [31:0] pcOut      [NI];
    logic [31:0] instr      [NI];
    logic        instrValid [NI];
    logic        halted     [NI];
    logic [31:0] retireCount[NI];

    // ROM contents knobs
    logic        haltEnable = 1'b0;
    logic [31:0] haltAddr   = 32'd0;

    // memory read pipeline (enough depth for latency up to 3)
    logic [1:0]  pipeValid [NI] = '{default: 2'b00};
    logic [31:0] pipeAddr  [NI][2];

    // reference model
    logic [31:0] mPc    [NI];
    logic [31:0] mCnt   [NI];
    logic [31:0] mInstr [NI];
    logic        mValid [NI];
    logic        mHalted[NI];
    longint      issueAt[NI];
    longint      cyc;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    instr_fetch_unit #(.MEM_LAT(1), .HALT_OPCODE(6'b111111)) dutLat1 (
        .clock(clock), .reset(reset[0]), .pc_next(pcNext[0]), .stall(stall[0]),
        .imem_rdata(imemRdata[0]), .imem_addr(imemAddr[0]), .imem_rd_en(imemRdEn[0]),
        .pc_out(pcOut[0]), .instr(instr[0]), .instr_valid(instrValid[0]),
        .halted(halted[0]), .retire_count(retireCount[0])
    );

    instr_fetch_unit #(.MEM_LAT(3), .HALT_OPCODE(6'b111111)) dutLat3 (
        .clock(clock), .reset(reset[1]), .pc_next(pcNext[1]), .stall(stall[1]),
        .imem_rdata(imemRdata[1]), .imem_addr(imemAddr[1]), .imem_rd_en(imemRdEn[1]),
        .pc_out(pcOut[1]), .instr(instr[1]), .instr_valid(instrValid[1]),
        .halted(halted[1]), .retire_count(retireCount[1])
    );

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ROM image: small addresses hold addr|0x1000, high addresses a non-halt
    // opcode, and optionally one address holds a halt word.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        if (haltEnable && a == haltAddr) return {6'b111111, a[25:0]};
        if (a < 32'h1000) return a | 32'h1000;
        return {6'b000011, a[25:0]};
    endfunction

    // Instruction memory: data is valid exactly MEM_LAT cycles after the
    // strobe, random noise otherwise (noise may even look like a halt word).
    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            pipeValid[i]   <= {pipeValid[i][0], imemRdEn[i]};
            pipeAddr[i][0] <= imemAddr[i];
            pipeAddr[i][1] <= pipeAddr[i][0];
            if (latOf(i) == 1) begin
                imemRdata[i] <= imemRdEn[i] ? romWord(imemAddr[i]) : $urandom;
            end else begin
                imemRdata[i] <= pipeValid[i][latOf(i) - 2] ? romWord(pipeAddr[i][latOf(i) - 2]) : $urandom;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // compares every output of both units against the model for this cycle
    task automatic checkCycle();
        for (int i = 0; i < NI; i++) begin
            logic expRdEn;
            string p;
            p = $sformatf("L%0d.", latOf(i));
            expRdEn = !mHalted[i] && (cyc == issueAt[i]);
            checkOutput({p, "pc_out"},       pcOut[i],            mPc[i]);
            checkOutput({p, "imem_addr"},    imemAddr[i],         mPc[i]);
            checkOutput({p, "imem_rd_en"},   32'(imemRdEn[i]),    32'(expRdEn));
            checkOutput({p, "instr"},        instr[i],            mInstr[i]);
            checkOutput({p, "instr_valid"},  32'(instrValid[i]),  32'(mValid[i]));
            checkOutput({p, "halted"},       32'(halted[i]),      32'(mHalted[i]));
            checkOutput({p, "retire_count"}, retireCount[i],      mCnt[i]);
        end
    endtask

    // picks reset/stall/pc_next for the current cycle
    task automatic applyStimulus(input int mode, input int k, input bit startReset);
        for (int i = 0; i < NI; i++) begin
            reset[i] = (k == 0 && startReset) || (mode == 3 && $urandom_range(0, 99) < 4);
            stall[i] = (mode != 0) && ($urandom_range(0, 99) < 30);
            if (mode <= 1 || mode == 4) begin
                pcNext[i] = mPc[i] + 32'd1;
            end else begin
                case ($urandom_range(0, 5))
                    0:       pcNext[i] = 32'h40;
                    1:       pcNext[i] = 32'hFFFF_FFFF;
                    2:       pcNext[i] = 32'd0;
                    3:       pcNext[i] = $urandom;
                    default: pcNext[i] = mPc[i] + 32'd1;
                endcase
            end
        end
    endtask

    // advances the reference across the coming clock edge: a read issued in
    // cycle t returns in cycle t+LAT, the word shows as valid the cycle after,
    // and a non-stalled valid cycle retires and issues again next cycle.
    task automatic modelStep();
        for (int i = 0; i < NI; i++) begin
            if (reset[i]) begin
                mPc[i] = 0; mCnt[i] = 0; mInstr[i] = 0;
                mValid[i] = 0; mHalted[i] = 0;
                issueAt[i] = cyc + 2;
            end else if (!mHalted[i]) begin
                if (cyc == issueAt[i] + longint'(latOf(i))) begin
                    mInstr[i] = romWord(mPc[i]);
                    if (mInstr[i][31:26] == 6'b111111) mHalted[i] = 1'b1;
                    else mValid[i] = 1'b1;
                end else if (mValid[i] && !stall[i]) begin
                    mPc[i]     = pcNext[i];
                    mCnt[i]    = mCnt[i] + 32'd1;
                    mValid[i]  = 1'b0;
                    issueAt[i] = cyc + 1;
                end
            end
        end
    endtask

    task automatic runCycles(input int mode, input int n, input bit startReset);
        for (int k = 0; k < n; k++) begin
            checkCycle();
            applyStimulus(mode, k, startReset);
            modelStep();
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset[i] = 1'b1; stall[i] = 1'b0; pcNext[i] = 32'd0;
            mPc[i] = 0; mCnt[i] = 0; mInstr[i] = 0;
            mValid[i] = 0; mHalted[i] = 0; issueAt[i] = -100;
        end
        cyc = 0;
        repeat (2) @(posedge clock);
        #1;

        $display("[TB] sequential fetch, no stall");
        runCycles(0, 40, 1'b1);
        $display("[TB] sequential fetch with random stall");
        runCycles(1, 200, 1'b0);
        $display("[TB] redirects, wrap-around PCs, random stall");
        runCycles(2, 300, 1'b0);
        $display("[TB] random resets mid-fetch");
        runCycles(3, 300, 1'b0);

        $display("[TB] halt opcode at address 3");
        haltEnable = 1'b1;
        haltAddr   = 32'd3;
        runCycles(4, 80, 1'b1);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("L%0d.halt_pc", latOf(i)), pcOut[i], 32'd3);
            checkOutput($sformatf("L%0d.halt_flag", latOf(i)), 32'(halted[i]), 32'd1);
            checkOutput($sformatf("L%0d.halt_count", latOf(i)), retireCount[i], 32'd3);
        end

        $display("[TB] restart after halt");
        haltEnable = 1'b0;
        runCycles(2, 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
